// File: rtl/gb_pixel_scaler.sv
// gb_pixel_scaler: fetches Game Boy 2bpp pixels from a 160x144 framebuffer,
// upscales them by an integer factor with counters only, centres the image
// in the 640x480 raster and emits RGB plus timing aligned 3 fbclk after x/y.
// Optional build macro: GB_GRID_EN darkens the last sub-row/sub-column of
// every source pixel to give an LCD grid look.
module gb_pixel_scaler #(
  parameter int SCALE  = 3,
  parameter int GB_W   = 160,
  parameter int GB_H   = 144,
  parameter int WIN_X0 = 80,
  parameter int WIN_Y0 = 24,
  parameter logic [23:0] BORDER_RGB = 24'h202020,
  parameter logic [23:0] PAL0 = 24'hE0F8D0,
  parameter logic [23:0] PAL1 = 24'h88C070,
  parameter logic [23:0] PAL2 = 24'h346856,
  parameter logic [23:0] PAL3 = 24'h081820
) (
  input  logic        fbclk,
  input  logic        rst_b,
  input  logic [11:0] x_in,
  input  logic [11:0] y_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        border_in,
  output logic [14:0] fb_addr,
  output logic        fb_rd,
  input  logic [1:0]  fb_data,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic        frame_start
);

  // Window bounds and counter limits, sized to the signals they compare with.
  localparam logic [11:0] X0       = 12'(WIN_X0);
  localparam logic [11:0] X1       = 12'(WIN_X0 + GB_W * SCALE);
  localparam logic [11:0] Y0       = 12'(WIN_Y0);
  localparam logic [11:0] Y1       = 12'(WIN_Y0 + GB_H * SCALE);
  localparam logic [1:0]  S_LAST   = 2'(SCALE - 1);
  localparam logic [7:0]  GX_LAST  = 8'(GB_W - 1);
  localparam logic [7:0]  GY_LAST  = 8'(GB_H - 1);
  localparam logic [14:0] ROW_STEP = 15'(GB_W);

  // Pixel class carried down the pipe.
  localparam logic [1:0] CLS_BLANK  = 2'd0;
  localparam logic [1:0] CLS_BORDER = 2'd1;
  localparam logic [1:0] CLS_WIN    = 2'd2;

  // Counter state.
  logic [1:0]  sx, sy;
  logic [7:0]  gx, gy;
  logic [14:0] row_base;

  // Combinational current/next counter values.
  logic        in_x, in_y, in_win;
  logic [1:0]  sx_cur, sx_nxt, sy_cur;
  logic [7:0]  gx_cur, gx_nxt, gy_cur;
  logic [14:0] row_cur;
  logic [1:0]  cls_cur;

  // Pipeline registers.
  logic [1:0]  cls1, cls2;
  logic        hs1, hs2, vs1, vs2, de1, de2, rd2;
  logic [23:0] rgb_nxt;
  logic [23:0] pal_sel;

`ifdef GB_GRID_EN
  logic        grid1, grid2;
`endif

  // Halve each 8-bit channel of a packed RGB value.
  function automatic logic [23:0] halve_rgb(input logic [23:0] c);
    return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
  endfunction

  // Window membership of the current raster position.
  always_comb begin
    in_x   = (x_in >= X0) && (x_in < X1);
    in_y   = (y_in >= Y0) && (y_in < Y1);
    in_win = in_x && in_y;
    if (border_in) begin
      cls_cur = CLS_BLANK;
    end else if (in_win) begin
      cls_cur = CLS_WIN;
    end else begin
      cls_cur = CLS_BORDER;
    end
  end

  // Vertical counters: re-armed at the window top, stepped once per line at x==0.
  // The stepped value is used for the current pixel too so a window starting
  // at x==0 still sees the right source row.
  always_comb begin
    sy_cur  = sy;
    gy_cur  = gy;
    row_cur = row_base;
    if (x_in == 12'd0) begin
      if (y_in == Y0) begin
        sy_cur  = 2'd0;
        gy_cur  = 8'd0;
        row_cur = 15'd0;
      end else if (in_y) begin
        if (sy == S_LAST) begin
          sy_cur = 2'd0;
          if (gy != GY_LAST) begin
            gy_cur  = gy + 8'd1;
            row_cur = row_base + ROW_STEP;
          end else begin
            gy_cur  = gy;
            row_cur = row_base;
          end
        end else begin
          sy_cur = sy + 2'd1;
        end
      end else begin
        sy_cur = sy;
      end
    end else begin
      sy_cur = sy;
    end
  end

  // Horizontal counters: cleared at the window's left edge, stepped while inside.
  always_comb begin
    if (x_in == X0) begin
      sx_cur = 2'd0;
      gx_cur = 8'd0;
    end else begin
      sx_cur = sx;
      gx_cur = gx;
    end
    sx_nxt = sx_cur;
    gx_nxt = gx_cur;
    if (in_win) begin
      if (sx_cur == S_LAST) begin
        sx_nxt = 2'd0;
        if (gx_cur != GX_LAST) begin
          gx_nxt = gx_cur + 8'd1;
        end else begin
          gx_nxt = gx_cur;
        end
      end else begin
        sx_nxt = sx_cur + 2'd1;
      end
    end else begin
      sx_nxt = sx_cur;
    end
  end

  // Counter state and stage-1 fetch request / frame pulse.
  always_ff @(posedge fbclk) begin
    if (!rst_b) begin
      sx          <= 2'd0;
      gx          <= 8'd0;
      sy          <= 2'd0;
      gy          <= 8'd0;
      row_base    <= 15'd0;
      fb_addr     <= 15'd0;
      fb_rd       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      sx          <= sx_nxt;
      gx          <= gx_nxt;
      sy          <= sy_cur;
      gy          <= gy_cur;
      row_base    <= row_cur;
      fb_addr     <= row_cur + {7'd0, gx_cur};
      fb_rd       <= in_win;
      frame_start <= (x_in == 12'd0) && (y_in == 12'd0);
    end
  end

  // Class and timing bits travel alongside the fetch (stages 1 and 2).
  always_ff @(posedge fbclk) begin
    if (!rst_b) begin
      cls1 <= CLS_BLANK;
      cls2 <= CLS_BLANK;
      hs1  <= 1'b0;
      hs2  <= 1'b0;
      vs1  <= 1'b0;
      vs2  <= 1'b0;
      de1  <= 1'b0;
      de2  <= 1'b0;
      rd2  <= 1'b0;
    end else begin
      cls1 <= cls_cur;
      cls2 <= cls1;
      hs1  <= hs_in;
      hs2  <= hs1;
      vs1  <= vs_in;
      vs2  <= vs1;
      de1  <= !border_in;
      de2  <= de1;
      rd2  <= fb_rd;
    end
  end

`ifdef GB_GRID_EN
  // Grid flag: last sub-column or sub-row of a source pixel, piped to stage 3.
  always_ff @(posedge fbclk) begin
    if (!rst_b) begin
      grid1 <= 1'b0;
      grid2 <= 1'b0;
    end else begin
      grid1 <= (sx_cur == S_LAST) || (sy_cur == S_LAST);
      grid2 <= grid1;
    end
  end
`endif

  // Palette lookup and colour selection for the output register.
  always_comb begin
    case (fb_data)
      2'd0:    pal_sel = PAL0;
      2'd1:    pal_sel = PAL1;
      2'd2:    pal_sel = PAL2;
      2'd3:    pal_sel = PAL3;
      default: pal_sel = PAL0;
    endcase
    rgb_nxt = 24'h000000;
    if ((cls2 == CLS_WIN) && rd2) begin
`ifdef GB_GRID_EN
      if (grid2) begin
        rgb_nxt = halve_rgb(pal_sel);
      end else begin
        rgb_nxt = pal_sel;
      end
`else
      rgb_nxt = pal_sel;
`endif
    end else if (cls2 == CLS_BORDER) begin
      rgb_nxt = BORDER_RGB;
    end else begin
      rgb_nxt = 24'h000000;
    end
  end

  // Stage 3: registered RGB and timing outputs.
  always_ff @(posedge fbclk) begin
    if (!rst_b) begin
      r      <= 8'd0;
      g      <= 8'd0;
      b      <= 8'd0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      de_out <= 1'b0;
    end else begin
      r      <= rgb_nxt[23:16];
      g      <= rgb_nxt[15:8];
      b      <= rgb_nxt[7:0];
      hs_out <= hs2;
      vs_out <= vs2;
      de_out <= de2;
    end
  end

endmodule

// File: doc/gb_pixel_scaler.md
Name: gb_pixel_scaler

Overview:
- Consumes the raster position and timing strobes from the VGA/DVI sync generator and produces aligned 24-bit RGB pixels for the DVI encoder.
- Fetches Game Boy 2bpp pixels from the 160x144 framebuffer RAM and upscales them by integer SCALE using counters, with no divider.
- Centres the scaled image in the 640x480 raster, fills the remaining active area with a border colour, and outputs black during blanking.
- Delays hs, vs and data-enable so they stay aligned with the RGB output.

Parameters:
- SCALE, 3: integer upscale factor, horizontal and vertical. Valid range 1..4.
- GB_W, 160: source width in pixels.
- GB_H, 144: source height in lines.
- WIN_X0, 80: first raster x of the scaled window. Default is (640-160*3)/2.
- WIN_Y0, 24: first raster y of the scaled window. Default is (480-144*3)/2.
- BORDER_RGB, 24'h202020: colour for active pixels outside the window.
- PAL0..PAL3, 24'hE0F8D0 / 24'h88C070 / 24'h346856 / 24'h081820: palette for shade codes 0..3.

Ports:
- fbclk, in, 1: pixel clock. Same clock as the sync generator.
- rst_b, in, 1: synchronous reset, active-low.
- x_in, in, 12: raster x from the sync generator.
- y_in, in, 12: raster y from the sync generator.
- hs_in, in, 1: horizontal sync, combinational from x_in.
- vs_in, in, 1: vertical sync, combinational from y_in.
- border_in, in, 1: 1 when outside the active 640x480 area.
- fb_addr, out, 15: framebuffer read address, gy*GB_W+gx.
- fb_rd, out, 1: read strobe, high when fb_addr is valid.
- fb_data, in, 2: shade code. Registered RAM output, valid exactly 1 cycle after fb_rd.
- r, out, 8; g, out, 8; b, out, 8: pixel colour.
- hs_out, out, 1; vs_out, out, 1; de_out, out, 1: timing delayed to match RGB. de_out = !border_in, delayed.
- frame_start, out, 1: one-cycle pulse at raster (0,0). Used by the CPU side for buffer swap.

Behaviour:
- Reset: all outputs and pipeline registers go to 0, including r, g, b, hs_out, vs_out, de_out, fb_rd, fb_addr, frame_start. All counters clear to 0.
- Stage 0 (counters), registered each fbclk:
  - in_win = x_in in [WIN_X0, WIN_X0+GB_W*SCALE) AND y_in in [WIN_Y0, WIN_Y0+GB_H*SCALE).
  - Horizontal: at x_in==WIN_X0, clear sx and gx. While in_win, sx increments; when sx==SCALE-1, sx goes to 0 and gx increments.
  - Vertical: updated only at x_in==0. At y_in==WIN_Y0, clear sy and gy. For y_in inside the window (excluding WIN_Y0), sy increments; when sy==SCALE-1, sy goes to 0 and gy increments.
  - gy holds its value outside the window. gx never exceeds GB_W-1 and gy never exceeds GB_H-1.
  - The row base gy*GB_W is kept as a running sum (add GB_W when gy increments, clear with gy). No multiplier.
- Stage 1: fb_addr = row_base+gx and fb_rd = in_win, both registered. Class (window/border/blank) and timing bits are piped alongside.
- Stage 2: fb_data arrives and is piped with class.
- Stage 3: RGB register.
  - blank: 0.
  - border: BORDER_RGB.
  - window: PALn for n = fb_data.
- Latency: exactly 3 fbclk from x_in/y_in to r/g/b, hs_out, vs_out, de_out. All four stay mutually aligned.
- frame_start is asserted on the cycle when x_in==0 && y_in==0 is registered. It carries no pipeline delay.
- Boundaries:
  - Raster wrap from x=XTOTAL to 0 needs no special case, because the counters re-arm at WIN_X0/WIN_Y0.
  - A window edge coincident with the border edge is legal.
  - rst_b low mid-frame clears everything in the next cycle. The first full picture starts at the next WIN_Y0 crossing.
  - fb_data is ignored whenever the piped fb_rd is 0.

Optional Feature:
- Macro: GB_GRID_EN.
- When defined: window pixels with sx==SCALE-1 or sy==SCALE-1 (last sub-row or sub-column of each source pixel) output the palette colour halved per channel ({1'b0, c[7:1]}). This gives an LCD grid look. Latency is unchanged; sx and sy are piped to stage 3.
- When undefined: no grid logic and no extra pipe bits; all window pixels are full palette colour.

Test Plan:
- Reset held 5 cycles while x/y run: all outputs 0. After release, the first RGB appears 3 cycles after inputs.
- x_in=79,y_in=24: border RGB 202020, fb_rd=0. x_in=80,y_in=24: fb_rd=1, fb_addr=0. fb_data=3 gives RGB 081820 at +3 cycles.
- Row y_in=24, x_in=80..559: fb_addr steps 0,0,0,1,1,1…159,159,159, and fb_rd drops at x_in=560.
- Line y_in=27: fb_addr starts at 160. Line y_in=455: starts at 143*160=22880. y_in=456: fb_rd=0.
- Full 800x525 frame: hs_out/vs_out equal hs_in/vs_in delayed 3 cycles. frame_start pulses once per frame. de_out is high for 640x480 pixels.
- With GB_GRID_EN, fb_data=0 at x_in=82,y_in=24 (sx=2) gives RGB 707C68. Without the macro the same pixel gives E0F8D0.
